// File: rtl/mpu_pkg.sv
// Shared encodings, ALU operation enum and pipeline stage records for the mpu_pipe core.
// Stage records carry data in XLEN_MAX-wide words; the core uses the low XLEN bits.
package mpu_pkg;

    localparam int XLEN_MAX = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    typedef logic [XLEN_MAX-1:0] word_t;

    typedef struct packed {
        logic    valid;
        logic    illegal;
        logic [4:0] rd;
        word_t   op_a;
        word_t   op_b;
        alu_op_e alu_op;
    } ex_stage_t;

    typedef struct packed {
        logic  valid;
        logic  illegal;
        logic [4:0] rd;
        word_t result;
    } wb_stage_t;

    // The alt bit selects SUB/SRA; callers decide when alt is meaningful.
    function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic word_t imm_i(input logic [31:0] ins);
        return {{(XLEN_MAX-12){ins[31]}}, ins[31:20]};
    endfunction

endpackage

// File: rtl/mpu_pipe_regfile.sv
// NREGS x XLEN register file: two asynchronous read ports, one write port, x0 tied to zero.
// Reads see a same-cycle write so the decode stage never needs a WB bypass of its own.
module regfile_nxw #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0)                ? '0    :
                     (we && waddr == raddr_a)       ? wdata : regs[raddr_a];
    assign rdata_b = (raddr_b == '0)                ? '0    :
                     (we && waddr == raddr_b)       ? wdata : regs[raddr_b];

endmodule

// File: rtl/mpu_pipe.sv
// Three-stage ID/EX/WB pipeline for RV32I OP and OP-IMM with valid/ready issue and global stall.
// FORWARD selects EX/WB operand bypass (never stalls) or a scoreboard-free interlock.
module mpu_pipe
    import mpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int FORWARD = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(XLEN);

    ex_stage_t       ex_q;
    ex_stage_t       ex_d;
    wb_stage_t       wb_q;
    wb_stage_t       wb_d;

    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [AW-1:0]   rs1_idx;
    logic [AW-1:0]   rs2_idx;
    logic [AW-1:0]   rd_idx;
    logic [4:0]      rs1_ext;
    logic [4:0]      rs2_ext;

    logic            dec_legal;
    logic            dec_use_rs2;
    alu_op_e         dec_op;

    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] rf_rdata_a;
    logic [XLEN-1:0] rf_rdata_b;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] alu_res;

    logic            ex_writes;
    logic            wb_writes;
    logic            hazard;
    logic            fire;
    logic            rf_we;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign rd_idx  = instr[7 +: AW];
    assign rs1_idx = instr[15 +: AW];
    assign rs2_idx = instr[20 +: AW];
    assign rs1_ext = 5'(rs1_idx);
    assign rs2_ext = 5'(rs2_idx);
    assign imm_val = XLEN'(imm_i(instr));

    // The alt encoding only means SUB/SRA on the two funct3 values that have one.
    always_comb begin
        dec_legal   = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_op      = ALU_ADD;
        case (opcode)
            OPC_OP: begin
                dec_use_rs2 = 1'b1;
                dec_op      = f3_to_op(funct3, funct7 == F7_ALT);
                dec_legal   = (funct7 == F7_BASE) ||
                              (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
            end
            OPC_OP_IMM: begin
                dec_op = f3_to_op(funct3, funct3 == F3_SR && funct7 == F7_ALT);
                case (funct3)
                    F3_SLL:  dec_legal = (funct7 == F7_BASE);
                    F3_SR:   dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign ex_writes = ex_q.valid && !ex_q.illegal && (ex_q.rd != '0);
    assign wb_writes = wb_q.valid && !wb_q.illegal && (wb_q.rd != '0);

    // Youngest producer wins: the EX result overrides the older WB value.
    always_comb begin
        src_a = rf_rdata_a;
        src_b = rf_rdata_b;
        if (FORWARD != 0) begin
            if (ex_writes && ex_q.rd == rs1_ext) begin
                src_a = alu_res;
            end else if (wb_writes && wb_q.rd == rs1_ext) begin
                src_a = wb_q.result[XLEN-1:0];
            end
            if (ex_writes && ex_q.rd == rs2_ext) begin
                src_b = alu_res;
            end else if (wb_writes && wb_q.rd == rs2_ext) begin
                src_b = wb_q.result[XLEN-1:0];
            end
        end
        if (!dec_use_rs2) begin
            src_b = imm_val;
        end
    end

    always_comb begin
        hazard = 1'b0;
        if (FORWARD == 0 && instr_valid && dec_legal) begin
            if ((ex_writes && ex_q.rd == rs1_ext) || (wb_writes && wb_q.rd == rs1_ext)) begin
                hazard = 1'b1;
            end
            if (dec_use_rs2 &&
                ((ex_writes && ex_q.rd == rs2_ext) || (wb_writes && wb_q.rd == rs2_ext))) begin
                hazard = 1'b1;
            end
        end
    end

    assign instr_ready = !stall && !hazard;
    assign fire        = instr_valid && instr_ready;

    // Illegal slots travel as bubbles with zeroed rd/operands so they can never write.
    always_comb begin
        ex_d         = '0;
        ex_d.valid   = 1'b1;
        ex_d.illegal = !dec_legal;
        if (dec_legal) begin
            ex_d.rd     = 5'(rd_idx);
            ex_d.op_a   = word_t'(src_a);
            ex_d.op_b   = word_t'(src_b);
            ex_d.alu_op = dec_op;
        end
    end

    assign alu_a = ex_q.op_a[XLEN-1:0];
    assign alu_b = ex_q.op_b[XLEN-1:0];
    assign shamt = alu_b[SW-1:0];

    always_comb begin
        case (ex_q.alu_op)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_SLL:  alu_res = alu_a << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_SRL:  alu_res = alu_a >> shamt;
            ALU_SRA:  alu_res = $signed(alu_a) >>> shamt;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            default:  alu_res = alu_a + alu_b;
        endcase
    end

    always_comb begin
        wb_d         = '0;
        wb_d.valid   = ex_q.valid;
        wb_d.illegal = ex_q.illegal;
        wb_d.rd      = ex_q.rd;
        wb_d.result  = word_t'(alu_res);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q <= '0;
            wb_q <= '0;
        end else if (!stall) begin
            if (fire) begin
                ex_q <= ex_d;
            end else begin
                ex_q <= '0;
            end
            wb_q <= wb_d;
        end
    end

    assign wb_valid = wb_q.valid && !wb_q.illegal;
    assign illegal  = wb_q.valid && wb_q.illegal;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.result[XLEN-1:0];
    assign rf_we    = wb_writes && !stall;

    regfile_nxw #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rs1_idx),
        .raddr_b (rs2_idx),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (wb_q.rd[AW-1:0]),
        .wdata   (wb_q.result[XLEN-1:0])
    );

endmodule

// File: tb/tb_mpu_pipe.sv
// Directed bench for mpu_pipe: one forwarding and one interlocked instance share clock, reset and stall.
// Retirements are collected per instance and compared against hand-computed sequences.
module tb_mpu_pipe;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        stall;

    logic        valid_f, ready_f, wbv_f, ill_f;
    logic [31:0] instr_f, data_f;
    logic [4:0]  rd_f;
    logic        valid_i, ready_i, wbv_i, ill_i;
    logic [31:0] instr_i, data_i;
    logic [4:0]  rd_i;

    typedef struct packed {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } ret_t;

    ret_t q_f[$];
    ret_t q_i[$];
    int   check_count = 0;
    int   error_count = 0;
    int   waits;
    int   wait_sum;

    always #5 clock = ~clock;

    mpu_pipe #(.XLEN(32), .NREGS(32), .FORWARD(1)) u_fwd (
        .clock(clock), .reset(rst_n), .instr_valid(valid_f), .instr(instr_f),
        .instr_ready(ready_f), .stall(stall), .wb_valid(wbv_f), .wb_rd(rd_f),
        .wb_data(data_f), .illegal(ill_f)
    );

    mpu_pipe #(.XLEN(32), .NREGS(32), .FORWARD(0)) u_ilk (
        .clock(clock), .reset(rst_n), .instr_valid(valid_i), .instr(instr_i),
        .instr_ready(ready_i), .stall(stall), .wb_valid(wbv_i), .wb_rd(rd_i),
        .wb_data(data_i), .illegal(ill_i)
    );

    // A slot retires only in a cycle that is not stalled.
    always @(negedge clock) begin
        if (rst_n && !stall) begin
            if (wbv_f || ill_f) q_f.push_back('{ill_f, rd_f, data_f});
            if (wbv_i || ill_i) q_i.push_back('{ill_i, rd_i, data_i});
        end
    end

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit ilk, input logic [31:0] ins, output int n_wait);
        bit accepted;
        accepted = 1'b0;
        n_wait   = 0;
        if (ilk) begin valid_i = 1'b1; instr_i = ins; end
        else     begin valid_f = 1'b1; instr_f = ins; end
        while (!accepted && n_wait < 10) begin
            @(negedge clock);
            if (ilk ? ready_i : ready_f) accepted = 1'b1;
            else n_wait++;
        end
        if (accepted) begin
            @(posedge clock);
            #1;
        end else begin
            checkOutput("issue timeout", 32'd0, 32'd1);
        end
        if (ilk) valid_i = 1'b0;
        else     valid_f = 1'b0;
    endtask

    task automatic expectRetire(input bit ilk, input string tag, input logic ill,
                                input logic [4:0] rd, input logic [31:0] data);
        ret_t r;
        int   sz;
        sz = ilk ? q_i.size() : q_f.size();
        checkOutput({tag, " present"}, (sz > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sz > 0) begin
            r = ilk ? q_i.pop_front() : q_f.pop_front();
            checkOutput({tag, " illegal"}, 32'(r.ill), 32'(ill));
            checkOutput({tag, " rd"},      32'(r.rd),  32'(rd));
            checkOutput({tag, " data"},    r.data,     data);
        end
    endtask

    task automatic expectDrained(input bit ilk, input string tag);
        checkOutput({tag, " queue empty"}, ilk ? 32'(q_i.size()) : 32'(q_f.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1; stall = 1'b0;
        valid_f = 1'b0; instr_f = '0; valid_i = 1'b0; instr_i = '0;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset wb_valid", 32'(wbv_f), 32'd0);
        checkOutput("reset illegal",  32'(ill_f), 32'd0);
        checkOutput("reset wb_rd",    32'(rd_f),  32'd0);
        checkOutput("reset wb_data",  data_f,     32'd0);
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        checkOutput("ready after reset", 32'(ready_f), 32'd1);
        idle(1);

        $display("[TB] forwarding dependency chain");
        wait_sum = 0;
        applyStimulus(1'b0, itype(12'd5, 5'd0, 3'b000, 5'd1), waits);     wait_sum += waits;
        applyStimulus(1'b0, itype(12'hFFD, 5'd0, 3'b000, 5'd2), waits);   wait_sum += waits;
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), waits); wait_sum += waits;
        checkOutput("fwd ready never low", 32'(wait_sum), 32'd0);
        idle(1);
        @(negedge clock);
        checkOutput("fwd add latency valid", 32'(wbv_f), 32'd1);
        checkOutput("fwd add latency rd",    32'(rd_f),  32'd3);
        checkOutput("fwd add latency data",  data_f,     32'd2);
        idle(3);
        expectRetire(1'b0, "fwd x1", 1'b0, 5'd1, 32'd5);
        expectRetire(1'b0, "fwd x2", 1'b0, 5'd2, 32'hFFFF_FFFD);
        expectRetire(1'b0, "fwd x3", 1'b0, 5'd3, 32'd2);
        expectDrained(1'b0, "fwd");

        $display("[TB] interlock dependency chain");
        applyStimulus(1'b1, itype(12'd5, 5'd0, 3'b000, 5'd1), waits);
        checkOutput("ilk x1 waits", 32'(waits), 32'd0);
        applyStimulus(1'b1, itype(12'hFFD, 5'd0, 3'b000, 5'd2), waits);
        checkOutput("ilk x2 waits", 32'(waits), 32'd0);
        applyStimulus(1'b1, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), waits);
        checkOutput("ilk add waits", 32'(waits), 32'd2);
        idle(4);
        expectRetire(1'b1, "ilk x1", 1'b0, 5'd1, 32'd5);
        expectRetire(1'b1, "ilk x2", 1'b0, 5'd2, 32'hFFFF_FFFD);
        expectRetire(1'b1, "ilk x3", 1'b0, 5'd3, 32'd2);
        expectDrained(1'b1, "ilk");

        $display("[TB] shifts and compares");
        applyStimulus(1'b0, itype(12'd1, 5'd0, 3'b000, 5'd1), waits);
        applyStimulus(1'b0, itype(12'd31, 5'd1, 3'b001, 5'd1), waits);
        applyStimulus(1'b0, itype(12'h404, 5'd1, 3'b101, 5'd5), waits);
        applyStimulus(1'b0, rtype(7'h00, 5'd1, 5'd0, 3'b011, 5'd6), waits);
        applyStimulus(1'b0, rtype(7'h00, 5'd0, 5'd1, 3'b010, 5'd7), waits);
        idle(4);
        expectRetire(1'b0, "addi x1",  1'b0, 5'd1, 32'd1);
        expectRetire(1'b0, "slli x1",  1'b0, 5'd1, 32'h8000_0000);
        expectRetire(1'b0, "srai x5",  1'b0, 5'd5, 32'hF800_0000);
        expectRetire(1'b0, "sltu x6",  1'b0, 5'd6, 32'd1);
        expectRetire(1'b0, "slt x7",   1'b0, 5'd7, 32'd1);
        expectDrained(1'b0, "shift");

        $display("[TB] x0 writes");
        applyStimulus(1'b0, itype(12'd7, 5'd0, 3'b000, 5'd0), waits);
        applyStimulus(1'b0, rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd4), waits);
        idle(4);
        expectRetire(1'b0, "addi x0", 1'b0, 5'd0, 32'd7);
        expectRetire(1'b0, "add x4",  1'b0, 5'd4, 32'd0);
        expectDrained(1'b0, "x0");

        $display("[TB] illegal slot and stall");
        applyStimulus(1'b0, itype(12'd11, 5'd0, 3'b000, 5'd8), waits);
        applyStimulus(1'b0, 32'h0000_0000, waits);
        applyStimulus(1'b0, itype(12'd1, 5'd8, 3'b000, 5'd9), waits);
        stall = 1'b1;
        valid_f = 1'b1;
        instr_f = itype(12'd1, 5'd9, 3'b000, 5'd10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checkOutput("stall illegal held", 32'(ill_f),   32'd1);
            checkOutput("stall wb_valid low", 32'(wbv_f),   32'd0);
            checkOutput("stall ready low",    32'(ready_f), 32'd0);
            @(posedge clock);
            #1;
        end
        stall = 1'b0;
        applyStimulus(1'b0, itype(12'd1, 5'd9, 3'b000, 5'd10), waits);
        checkOutput("post-stall issue waits", 32'(waits), 32'd0);
        applyStimulus(1'b0, itype(12'd1, 5'd10, 3'b000, 5'd11), waits);
        idle(4);
        expectRetire(1'b0, "addi x8",  1'b0, 5'd8,  32'd11);
        expectRetire(1'b0, "illegal",  1'b1, 5'd0,  32'd0);
        expectRetire(1'b0, "addi x9",  1'b0, 5'd9,  32'd12);
        expectRetire(1'b0, "addi x10", 1'b0, 5'd10, 32'd13);
        expectRetire(1'b0, "addi x11", 1'b0, 5'd11, 32'd14);
        expectDrained(1'b0, "stall");

        $display("[TB] reset with instructions in flight");
        applyStimulus(1'b0, itype(12'd100, 5'd0, 3'b000, 5'd1), waits);
        applyStimulus(1'b0, itype(12'd200, 5'd0, 3'b000, 5'd2), waits);
        valid_f = 1'b1;
        instr_f = itype(12'd300, 5'd0, 3'b000, 5'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset wb_valid", 32'(wbv_f), 32'd0);
        checkOutput("midreset illegal",  32'(ill_f), 32'd0);
        checkOutput("midreset wb_rd",    32'(rd_f),  32'd0);
        checkOutput("midreset wb_data",  data_f,     32'd0);
        valid_f = 1'b0;
        idle(2);
        rst_n = 1'b1;
        @(negedge clock);
        checkOutput("release ready fwd", 32'(ready_f), 32'd1);
        checkOutput("release ready ilk", 32'(ready_i), 32'd1);
        idle(3);
        expectDrained(1'b0, "after reset");
        applyStimulus(1'b0, rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), waits);
        applyStimulus(1'b0, rtype(7'h00, 5'd6, 5'd3, 3'b000, 5'd5), waits);
        applyStimulus(1'b0, itype(12'd0, 5'd7, 3'b000, 5'd7), waits);
        applyStimulus(1'b0, itype(12'd0, 5'd11, 3'b000, 5'd12), waits);
        idle(4);
        expectRetire(1'b0, "cleared x1+x2", 1'b0, 5'd4,  32'd0);
        expectRetire(1'b0, "cleared x3+x6", 1'b0, 5'd5,  32'd0);
        expectRetire(1'b0, "cleared x7",    1'b0, 5'd7,  32'd0);
        expectRetire(1'b0, "cleared x11",   1'b0, 5'd12, 32'd0);
        expectDrained(1'b0, "final");

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
